// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
// Shared definitions for the step/ramp controller slice:
//   state_t      - controller FSM states
//   DEF_*        - default parameter values used by step_ramp_controller
//                  and period_ramp
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_CONT  = 2'd1,
        RUN_COUNT = 2'd2
    } state_t;

    localparam int unsigned DEF_CNT_W        = 24;
    localparam int unsigned DEF_SPEED_W      = 4;
    localparam int unsigned DEF_STEP_W       = 16;
    localparam int unsigned DEF_BASE_PERIOD  = 1_000_000;
    localparam int unsigned DEF_SPEED_DELTA  = 60_000;
    localparam int unsigned DEF_START_PERIOD = 2_000_000;
    localparam int unsigned DEF_RAMP_DELTA   = 50_000;

endpackage

// File: rtl/period_ramp.sv
// period_ramp
// Computes the target step period from the speed index and step size, and
// holds the current (ramped) step period.
//   clk, rst    - clock, asynchronous active-high reset
//   load        - entry into a run state: current period <= START_PERIOD
//   advance     - a step interval just completed: move period toward target
//   speed       - speed index, larger is faster
//   half_step   - 1 halves the target period
//   period      - current period in clocks, used for the next interval
module period_ramp
    import step_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned SPEED_W      = DEF_SPEED_W,
    parameter int unsigned BASE_PERIOD  = DEF_BASE_PERIOD,
    parameter int unsigned SPEED_DELTA  = DEF_SPEED_DELTA,
    parameter int unsigned START_PERIOD = DEF_START_PERIOD,
    parameter int unsigned RAMP_DELTA   = DEF_RAMP_DELTA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    input  logic [SPEED_W-1:0] speed,
    input  logic               half_step,
    output logic [CNT_W-1:0]   period
);

    localparam logic [CNT_W-1:0] START    = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] RAMP     = CNT_W'(RAMP_DELTA);
    localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2);

    logic [31:0]      reduction;
    logic [31:0]      raw;
    logic [CNT_W-1:0] full;
    logic [CNT_W-1:0] scaled;
    logic [CNT_W-1:0] target;

    // Target is re-evaluated every cycle; a reduction larger than the base
    // saturates at zero and is then lifted by the minimum clamp.
    always_comb begin
        reduction = 32'(speed) * SPEED_DELTA;
        raw       = (reduction >= BASE_PERIOD) ? '0 : (BASE_PERIOD - reduction);
        full      = CNT_W'(raw);
        scaled    = half_step ? (full >> 1) : full;
        target    = (scaled < MIN_PER) ? MIN_PER : scaled;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= START;
        end else if (load) begin
            period <= START;
        end else if (advance) begin
            if (period > target) begin
                period <= ((period - target) > RAMP) ? (period - RAMP) : target;
            end else if (period < target) begin
                period <= ((target - period) > RAMP) ? (period + RAMP) : target;
            end
        end
    end

endmodule

// File: rtl/step_ramp_controller.sv
// step_ramp_controller
// Stepper pulse generator with continuous and counted moves and a period
// ramp limiting the change of step period per emitted step.
//   clk, rst          - clock, asynchronous active-high reset
//   enable            - run permission; low aborts any motion
//   operationModeKey  - 1 continuous, 0 counted move
//   stepSizeKey       - 0 full step, 1 half step
//   startKey          - single-cycle request for a counted move
//   speedValue        - speed index, larger is faster
//   moveSteps         - full-step count of a counted move
//   stepOut           - one-cycle step pulse
//   busy              - high in RUN_CONT / RUN_COUNT
//   doneOut           - one-cycle pulse at normal end of a counted move
//   stepsRemaining    - steps left in the current counted move
module step_ramp_controller
    import step_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned SPEED_W      = DEF_SPEED_W,
    parameter int unsigned STEP_W       = DEF_STEP_W,
    parameter int unsigned BASE_PERIOD  = DEF_BASE_PERIOD,
    parameter int unsigned SPEED_DELTA  = DEF_SPEED_DELTA,
    parameter int unsigned START_PERIOD = DEF_START_PERIOD,
    parameter int unsigned RAMP_DELTA   = DEF_RAMP_DELTA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               operationModeKey,
    input  logic               stepSizeKey,
    input  logic               startKey,
    input  logic [SPEED_W-1:0] speedValue,
    input  logic [STEP_W-1:0]  moveSteps,
    output logic               stepOut,
    output logic               busy,
    output logic               doneOut,
    output logic [STEP_W:0]    stepsRemaining
);

    localparam int unsigned REM_W = STEP_W + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             wrap;
    logic             go_cont;
    logic             go_count;
    logic             load;
    logic             advance;
    logic [REM_W-1:0] load_count;

    always_comb begin
        wrap       = (cnt == (period - CNT_W'(1)));
        go_cont    = enable & operationModeKey;
        go_count   = enable & ~operationModeKey & startKey & (|moveSteps);
        load       = (state == IDLE) & (go_cont | go_count);
        load_count = stepSizeKey ? {moveSteps, 1'b0} : {1'b0, moveSteps};
        advance    = 1'b0;
        case (state)
            RUN_CONT:  advance = wrap & enable & operationModeKey;
            RUN_COUNT: advance = wrap & enable;
            default:   advance = 1'b0;
        endcase
    end

    period_ramp #(
        .CNT_W        (CNT_W),
        .SPEED_W      (SPEED_W),
        .BASE_PERIOD  (BASE_PERIOD),
        .SPEED_DELTA  (SPEED_DELTA),
        .START_PERIOD (START_PERIOD),
        .RAMP_DELTA   (RAMP_DELTA)
    ) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .speed     (speedValue),
        .half_step (stepSizeKey),
        .period    (period)
    );

    // stepOut is registered from the wrap cycle, so the first pulse lands
    // START_PERIOD cycles after busy rises. The step count is consumed on the
    // cycle stepOut is high, which puts doneOut one cycle after the last pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            stepOut        <= 1'b0;
            busy           <= 1'b0;
            doneOut        <= 1'b0;
            stepsRemaining <= '0;
        end else begin
            stepOut <= 1'b0;
            doneOut <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (go_cont) begin
                        state <= RUN_CONT;
                        busy  <= 1'b1;
                    end else if (go_count) begin
                        state          <= RUN_COUNT;
                        busy           <= 1'b1;
                        stepsRemaining <= load_count;
                    end
                end
                RUN_CONT: begin
                    if (!(enable && operationModeKey)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt     <= wrap ? '0 : (cnt + CNT_W'(1));
                        stepOut <= wrap;
                    end
                end
                RUN_COUNT: begin
                    if (!enable) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        cnt            <= '0;
                        stepsRemaining <= '0;
                    end else if (stepOut && (stepsRemaining == REM_W'(1))) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        cnt            <= '0;
                        stepsRemaining <= '0;
                        doneOut        <= 1'b1;
                    end else begin
                        if (stepOut) begin
                            stepsRemaining <= stepsRemaining - REM_W'(1);
                        end
                        cnt     <= wrap ? '0 : (cnt + CNT_W'(1));
                        stepOut <= wrap;
                    end
                end
                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    cnt            <= '0;
                    stepsRemaining <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_ramp_controller.sv
// tb_step_ramp_controller
// Directed bench for step_ramp_controller with a small configuration.
// Expected step intervals are queued as each move is launched; a negedge
// monitor measures the interval to every stepOut pulse and pops/compares.
module tb_step_ramp_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       operationModeKey;
    logic       stepSizeKey;
    logic       startKey;
    logic [3:0] speedValue;
    logic [7:0] moveSteps;
    logic       stepOut;
    logic       busy;
    logic       doneOut;
    logic [8:0] stepsRemaining;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int since = 0;
    logic prev_busy = 1'b0;
    int done_seen = 0;

    always #5 clk = ~clk;

    step_ramp_controller #(
        .CNT_W        (8),
        .SPEED_W      (4),
        .STEP_W       (8),
        .BASE_PERIOD  (40),
        .SPEED_DELTA  (2),
        .START_PERIOD (40),
        .RAMP_DELTA   (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .operationModeKey (operationModeKey),
        .stepSizeKey      (stepSizeKey),
        .startKey         (startKey),
        .speedValue       (speedValue),
        .moveSteps        (moveSteps),
        .stepOut          (stepOut),
        .busy             (busy),
        .doneOut          (doneOut),
        .stepsRemaining   (stepsRemaining)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Interval measured from busy rising, or from the previous pulse.
    always @(negedge clk) begin
        if (rst) begin
            since     = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) since = 0;
            else since++;
            if (doneOut) done_seen++;
            if (stepOut) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'(stepOut), 0);
                end else begin
                    chk("interval", since, exp_q.pop_front());
                end
                since = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic start_move(input logic [7:0] steps);
        moveSteps = steps;
        startKey  = 1'b1;
        tick();
        startKey  = 1'b0;
    endtask

    initial begin
        int done_before;
        int n;

        rst = 1'b1; enable = 1'b0; operationModeKey = 1'b0; stepSizeKey = 1'b0;
        startKey = 1'b0; speedValue = '0; moveSteps = '0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_step", int'(stepOut), 0);
        chk("rst_done", int'(doneOut), 0);
        chk("rst_rem", int'(stepsRemaining), 0);
        tick();
        rst = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        chk("idle_after_rst", int'(busy), 0);

        // Counted full-step move of 3 at speed 0.
        exp_q.push_back(40); exp_q.push_back(40); exp_q.push_back(40);
        done_before = done_seen;
        start_move(8'd3);
        chk("cnt3_busy", int'(busy), 1);
        chk("cnt3_rem", int'(stepsRemaining), 3);
        wait_drain("cnt3", 200);
        chk("cnt3_done", int'(doneOut), 1);
        chk("cnt3_busy_low", int'(busy), 0);
        chk("cnt3_rem_end", int'(stepsRemaining), 0);
        tick();
        chk("cnt3_done_1cyc", int'(doneOut), 0);
        chk("cnt3_done_count", done_seen - done_before, 1);

        // Start with zero steps is ignored.
        start_move(8'd0);
        chk("zero_busy", int'(busy), 0);
        chk("zero_rem", int'(stepsRemaining), 0);

        // 5-step move; start while busy ignored; abort after 2nd pulse.
        exp_q.push_back(40); exp_q.push_back(40);
        done_before = done_seen;
        start_move(8'd5);
        chk("m5_rem", int'(stepsRemaining), 5);
        start_move(8'd9);
        moveSteps = 8'd5;
        chk("busy_start_rem", int'(stepsRemaining), 5);
        chk("busy_start_busy", int'(busy), 1);
        wait_drain("m5", 200);
        chk("m5_rem_after2", int'(stepsRemaining), 3);
        enable = 1'b0;
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_rem", int'(stepsRemaining), 0);
        chk("abort_step", int'(stepOut), 0);
        chk("abort_done", int'(doneOut), 0);
        repeat (45) tick();
        chk("abort_no_done", done_seen - done_before, 0);
        enable = 1'b1;

        // Half-step counted move: doubled count, ramp toward 20.
        stepSizeKey = 1'b1;
        exp_q.push_back(40); exp_q.push_back(36); exp_q.push_back(32);
        exp_q.push_back(28); exp_q.push_back(24); exp_q.push_back(20);
        done_before = done_seen;
        start_move(8'd3);
        chk("half_rem", int'(stepsRemaining), 6);
        wait_drain("half", 400);
        chk("half_done", int'(doneOut), 1);
        chk("half_busy_low", int'(busy), 0);
        tick();
        chk("half_done_count", done_seen - done_before, 1);
        stepSizeKey = 1'b0;

        // Continuous at speed 5 (target 30), then back to speed 0.
        done_before = done_seen;
        speedValue = 4'd5;
        exp_q.push_back(40); exp_q.push_back(36); exp_q.push_back(32); exp_q.push_back(30);
        operationModeKey = 1'b1;
        tick();
        chk("cont_busy", int'(busy), 1);
        wait_drain("cont_up", 400);
        speedValue = 4'd0;
        exp_q.push_back(30); exp_q.push_back(34); exp_q.push_back(38); exp_q.push_back(40);
        wait_drain("cont_down", 400);
        operationModeKey = 1'b0;
        tick();
        chk("cont_stop_busy", int'(busy), 0);
        chk("cont_stop_done", int'(doneOut), 0);
        tick();
        chk("cont_no_done", done_seen - done_before, 0);

        // Asynchronous reset during a step pulse.
        exp_q.push_back(40);
        start_move(8'd4);
        n = 0;
        while (stepOut !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("first_pulse_latency", n, 40);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_step", int'(stepOut), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(doneOut), 0);
        chk("arst_rem", int'(stepsRemaining), 0);
        exp_q.delete();
        enable = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
